// File: rtl/sram_ctrl.sv
// Bridges the 32-bit MEM-stage data access onto a 16-bit asynchronous SRAM.
// Each access is split into a low and a high half-word phase; the pipeline is stalled until DONE.
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 rd_q, rd_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   saddr_q;

  logic                 req;
  logic                 active;
  logic                 half;
  logic                 last;
  logic [SRAM_AW-2:0]   widx;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign active = (state_q == LOW) || (state_q == HIGH);
  assign half   = (state_q == HIGH);
  assign last   = (cnt_q == WAIT_LAST);

  // Out-of-range offsets simply wrap into the SRAM address space.
  assign widx = (SRAM_AW-1)'((addr_q - BASE_ADDR) >> 2);

  // Bus controls are decoded from state so an async reset releases the bus at once.
  assign sram_addr   = active ? {widx, half} : saddr_q;
  assign sram_dq_oe  = active && !rd_q;
  assign sram_we_n   = !(active && !rd_q);
  assign sram_dq_out = !sram_dq_oe ? 16'h0000 :
                       half        ? wdata_q[31:16] : wdata_q[15:0];

  assign rdata = rdata_q;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = !req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = 3'd0;
          rd_d    = MEM_R_EN;   // a read wins when both enables are raised
          addr_d  = address;
          wdata_d = wdata;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = 3'd0;
          if (rd_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          if (rd_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rd_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      saddr_q <= sram_addr;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM behavioural model plus a word-level reference memory.
// A second instance with WAIT_CYCLES=0 covers the held back-to-back read cadence.
module tb_sram_ctrl;

  localparam int AW = 18;
  localparam int N  = 2**AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance with WAIT_CYCLES=1
  logic          r_en = 0, w_en = 0;
  logic [31:0]   addr = 0, wd = 0;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] saddr;
  logic [15:0]   dq_out, dq_in;
  logic          oe, we_n;

  // instance with WAIT_CYCLES=0
  logic          r0 = 0, w0 = 0;
  logic [31:0]   a0 = 0, wd0 = 0;
  logic [31:0]   rd0;
  logic          rdy0;
  logic [AW-1:0] sa0;
  logic [15:0]   dqo0, dqi0;
  logic          oe0, we0;

  sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024), .SRAM_AW(AW)) u_dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .address(addr), .wdata(wd),
    .rdata(rdata), .ready(ready), .sram_addr(saddr), .sram_dq_out(dq_out),
    .sram_dq_in(dq_in), .sram_dq_oe(oe), .sram_we_n(we_n));

  sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024), .SRAM_AW(AW)) u_dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .address(a0), .wdata(wd0),
    .rdata(rd0), .ready(rdy0), .sram_addr(sa0), .sram_dq_out(dqo0),
    .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(we0));

  // Power-up contents: fixed values at half-words 2/3, a hash elsewhere.
  function automatic logic [15:0] init_val(input logic [AW-1:0] i);
    logic [31:0] t;
    if (i == 18'd2) return 16'h5678;
    if (i == 18'd3) return 16'h1234;
    t = {14'd0, i} * 32'd40503;
    return t[15:0] ^ 16'h5A5A;
  endfunction

  // SRAM model: asynchronous read, write on clock edge while we_n low
  logic [15:0] mem1 [0:N-1];
  bit          wr1  [0:N-1];
  assign dq_in = wr1[saddr] ? mem1[saddr] : init_val(saddr);
  assign dqi0  = init_val(sa0);
  always @(posedge clk) if (!we_n) begin
    mem1[saddr] <= dq_out;
    wr1[saddr]  <= 1'b1;
  end

  function automatic logic [15:0] sram1(input logic [AW-1:0] i);
    return wr1[i] ? mem1[i] : init_val(i);
  endfunction

  // Reference: half-word store keyed by SRAM address
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(input logic [AW-1:0] i);
    return ref_mem.exists(int'(i)) ? ref_mem[int'(i)] : init_val(i);
  endfunction

  function automatic logic [AW-1:0] hw(input logic [31:0] a, input bit h);
    logic [31:0] t;
    t = ((a - 32'd1024) / 4) * 2 + {31'd0, h};
    return t[AW-1:0];
  endfunction

  int n_cmp = 0, n_bad = 0;
  logic [31:0] last_rd = 0;

  logic [AW-1:0] tr_addr [0:39];
  logic [15:0]   tr_dq   [0:39];
  logic          tr_we   [0:39];
  logic          tr_oe   [0:39];

  // One access on the WAIT_CYCLES=1 instance; returns the cycle index where ready rose (-1 on timeout).
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int drop_at, output int lat);
    int cyc;
    cyc = 0;
    lat = -1;
    @(negedge clk);
    r_en = r; w_en = w; addr = a; wd = d;
    while (cyc < 40) begin
      #1;
      tr_addr[cyc] = saddr; tr_dq[cyc] = dq_out; tr_we[cyc] = we_n; tr_oe[cyc] = oe;
      if (cyc == drop_at) begin
        r_en = 0; w_en = 0; addr = $urandom; wd = $urandom;
      end
      if (ready) begin
        lat = cyc;
        r_en = 0; w_en = 0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    n_cmp++;
    if ({ready, rdata, saddr, dq_out, oe, we_n} !== {1'b1, 32'd0, 18'd0, 16'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b rd=%h a=%h dq=%h oe=%b we=%b", ready, rdata, saddr, dq_out, oe, we_n);
    end
    n_cmp++;
    if ({rdy0, rd0, we0, oe0} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_state0: got rdy=%b rd=%h we=%b oe=%b", rdy0, rd0, we0, oe0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({ready, we_n, saddr} !== {1'b1, 1'b1, 18'd0}) begin
        n_bad++; $display("FAIL post_reset_idle: got rdy=%b we=%b a=%h want 1 1 0", ready, we_n, saddr);
      end
    end
  endtask

  task automatic test_write_trace;
    int lat;
    logic [AW-1:0] ea;
    logic [15:0]   ed;
    access(0, 1, 32'd1024, 32'hDEADBEEF, -1, lat);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL write_latency: got %0d want 5", lat); end
    for (int c = 0; c <= 5; c++) begin
      if (c >= 1 && c <= 4) begin
        ea = (c <= 2) ? 18'd0 : 18'd1;
        ed = (c <= 2) ? 16'hBEEF : 16'hDEAD;
        n_cmp++;
        if ({tr_addr[c], tr_dq[c], tr_we[c], tr_oe[c]} !== {ea, ed, 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL write_trace c%0d: got a=%h dq=%h we=%b oe=%b want a=%h dq=%h we=0 oe=1",
                   c, tr_addr[c], tr_dq[c], tr_we[c], tr_oe[c], ea, ed);
        end
      end else begin
        n_cmp++;
        if ({tr_dq[c], tr_we[c], tr_oe[c]} !== {16'd0, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL write_idle_bus c%0d: got dq=%h we=%b oe=%b want 0 1 0", c, tr_dq[c], tr_we[c], tr_oe[c]);
        end
      end
    end
    n_cmp++;
    if (tr_addr[5] !== 18'd1) begin n_bad++; $display("FAIL addr_hold_done: got %h want 1", tr_addr[5]); end
    ref_mem[0] = 16'hBEEF; ref_mem[1] = 16'hDEAD;
    n_cmp++;
    if ({sram1(0), sram1(1)} !== {ref_rd(0), ref_rd(1)}) begin
      n_bad++; $display("FAIL write_contents: got %h %h want BEEF DEAD", sram1(0), sram1(1));
    end
    n_cmp++;
    if (rdata !== last_rd) begin n_bad++; $display("FAIL rdata_hold_write: got %h want %h", rdata, last_rd); end
  endtask

  task automatic test_read;
    int lat;
    access(1, 0, 32'd1028, 32'h0, -1, lat);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL read_latency: got %0d want 5", lat); end
    n_cmp++;
    if ({tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]} !== {18'd2, 18'd2, 18'd3, 18'd3}) begin
      n_bad++; $display("FAIL read_addr: got %h %h %h %h want 2 2 3 3", tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]);
    end
    for (int c = 0; c <= 5; c++) begin
      n_cmp++;
      if ({tr_we[c], tr_oe[c]} !== 2'b10) begin
        n_bad++; $display("FAIL read_strobe c%0d: got we=%b oe=%b want 1 0", c, tr_we[c], tr_oe[c]);
      end
    end
    last_rd = 32'h12345678;
    n_cmp++;
    if (rdata !== last_rd) begin n_bad++; $display("FAIL read_data: got %h want %h", rdata, last_rd); end
  endtask

  task automatic test_both_enables;
    int lat;
    bit saw_we;
    access(1, 1, 32'd1032, $urandom, -1, lat);
    saw_we = 0;
    for (int c = 0; c <= 5; c++) if (tr_we[c] !== 1'b1) saw_we = 1;
    n_cmp++;
    if (lat !== 5 || saw_we) begin n_bad++; $display("FAIL both_en_cycle: got lat=%0d we_low=%b want 5 0", lat, saw_we); end
    last_rd = {ref_rd(5), ref_rd(4)};
    n_cmp++;
    if (rdata !== last_rd) begin n_bad++; $display("FAIL both_en_rdata: got %h want %h", rdata, last_rd); end
    n_cmp++;
    if ({sram1(4), sram1(5)} !== {ref_rd(4), ref_rd(5)}) begin
      n_bad++; $display("FAIL both_en_contents: got %h %h want %h %h", sram1(4), sram1(5), ref_rd(4), ref_rd(5));
    end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] a, d;
    bit rd;
    for (int i = 0; i < 24; i++) begin
      rd = $urandom_range(0, 1);
      if (i % 6 == 5) a = 32'd1024 - 32'd4 * $urandom_range(1, 8);   // below base: wraps
      else            a = 32'd1024 + 32'd4 * $urandom_range(8, 23);
      d = $urandom;
      access(rd, !rd, a, d, -1, lat);
      n_cmp++;
      if (lat !== 5 || tr_addr[1] !== hw(a, 0) || tr_addr[3] !== hw(a, 1)) begin
        n_bad++;
        $display("FAIL rand_access %0d: got lat=%0d a=%h/%h want 5 %h/%h", i, lat, tr_addr[1], tr_addr[3], hw(a, 0), hw(a, 1));
      end
      if (rd) begin
        last_rd = {ref_rd(hw(a, 1)), ref_rd(hw(a, 0))};
        n_cmp++;
        if (rdata !== last_rd) begin n_bad++; $display("FAIL rand_read %0d: got %h want %h", i, rdata, last_rd); end
      end else begin
        ref_mem[int'(hw(a, 0))] = d[15:0];
        ref_mem[int'(hw(a, 1))] = d[31:16];
        n_cmp++;
        if ({sram1(hw(a, 1)), sram1(hw(a, 0)), rdata} !== {d, last_rd}) begin
          n_bad++;
          $display("FAIL rand_write %0d: got mem=%h%h rd=%h want %h %h", i, sram1(hw(a, 1)), sram1(hw(a, 0)), rdata, d, last_rd);
        end
      end
    end
  endtask

  task automatic test_drop;
    int lat;
    logic [31:0] a, d;
    a = 32'd1024 + 32'd4 * 30;
    access(1, 0, a, 32'h0, 1, lat);
    last_rd = {ref_rd(hw(a, 1)), ref_rd(hw(a, 0))};
    n_cmp++;
    if (lat !== 5 || rdata !== last_rd) begin
      n_bad++; $display("FAIL drop_read: got lat=%0d rd=%h want 5 %h", lat, rdata, last_rd);
    end
    repeat (3) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({ready, we_n} !== 2'b11) begin n_bad++; $display("FAIL drop_idle: got rdy=%b we=%b want 1 1", ready, we_n); end
    end
    a = 32'd1024 + 32'd4 * 31;
    d = $urandom;
    access(0, 1, a, d, 2, lat);
    ref_mem[int'(hw(a, 0))] = d[15:0];
    ref_mem[int'(hw(a, 1))] = d[31:16];
    n_cmp++;
    if (lat !== 5 || {sram1(hw(a, 1)), sram1(hw(a, 0))} !== d) begin
      n_bad++; $display("FAIL drop_write: got lat=%0d mem=%h%h want 5 %h", lat, sram1(hw(a, 1)), sram1(hw(a, 0)), d);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] a, d;
    a = 32'd1024 + 32'd4 * 40;
    d = $urandom;
    @(negedge clk);
    w_en = 1; addr = a; wd = d;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({we_n, saddr} !== {1'b0, hw(a, 1)}) begin
      n_bad++; $display("FAIL abort_in_high: got we=%b a=%h want 0 %h", we_n, saddr, hw(a, 1));
    end
    rst = 1'b0; w_en = 0;
    #1;
    n_cmp++;
    if ({we_n, oe, ready, rdata, dq_out} !== {1'b1, 1'b0, 1'b1, 32'd0, 16'd0}) begin
      n_bad++; $display("FAIL abort_outputs: got we=%b oe=%b rdy=%b rd=%h dq=%h want 1 0 1 0 0", we_n, oe, ready, rdata, dq_out);
    end
    last_rd = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    ref_mem[int'(hw(a, 0))] = d[15:0];
    n_cmp++;
    if ({sram1(hw(a, 1)), sram1(hw(a, 0)), ready} !== {ref_rd(hw(a, 1)), ref_rd(hw(a, 0)), 1'b1}) begin
      n_bad++; $display("FAIL abort_contents: got %h %h rdy=%b want %h %h 1",
                        sram1(hw(a, 1)), sram1(hw(a, 0)), ready, ref_rd(hw(a, 1)), ref_rd(hw(a, 0)));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd;
    bit exp_rdy;
    @(negedge clk);
    r0 = 1;
    a0 = 32'd1024 + 32'd4 * $urandom_range(0, 4000);
    for (int c = 0; c < 32; c++) begin
      #1;
      exp_rdy = (c % 4 == 3);
      n_cmp++;
      if ({rdy0, we0, oe0, dqo0} !== {exp_rdy, 1'b1, 1'b0, 16'd0}) begin
        n_bad++; $display("FAIL b2b_ready c%0d: got rdy=%b we=%b oe=%b dq=%h want %b 1 0 0", c, rdy0, we0, oe0, dqo0, exp_rdy);
      end
      if (exp_rdy) begin
        exp_rd = {init_val(hw(a0, 1)), init_val(hw(a0, 0))};
        n_cmp++;
        if (rd0 !== exp_rd) begin n_bad++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, rd0, exp_rd); end
        a0 = 32'd1024 + 32'd4 * $urandom_range(0, 4000);
      end
      @(negedge clk);
    end
    r0 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_trace();
    test_read();
    test_both_enables();
    test_random();
    test_drop();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
